ex_stage_md: RTL and testbench

- Parametrised next-generation execute stage for the MIPS pipeline, sitting between ID/EX and EX/MEM.
- Adds an XLEN-wide datapath, architectural HI/LO registers, and an iterative multiply/divide unit.
- Non-HI/LO instructions overlap with a running mult/div; only HI/LO consumers are held back by a stall request to the hazard unit.
- ALU arithmetic comes from the existing alu/alucontrol pair, instantiated at the same level; this block owns operand routing, link/destination muxing, branch/jump targets, mult/div, HI/LO and the EX/MEM register.

---
 rtl/ex_md_pkg.sv | 33 +++
 rtl/md_unit.sv | 149 ++++++++++++++
 rtl/ex_stage_md.sv | 176 +++++++++++++++++
 tb/tb_ex_stage_md.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_md_pkg.sv
// Shared encodings for the execute stage: md_op codes, mult/div FSM states, op-class helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ex_md_pkg;

  // md_op encodings presented by the decoder; unlisted codes behave as MD_NONE
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // mult/div sequencer states
  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_MUL  = 2'd1;
  localparam md_state_t ST_DIV  = 2'd2;

  // op starts an iterative multiply or divide
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // op reads, writes or produces HI/LO
  function automatic logic md_is_hilo(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO pair.
// Latency: MUL_CYCLES cycles for MULT(U), XLEN cycles for DIV(U); HI/LO update on the final edge.
// Backpressure: start is honoured only while idle; rd_wait tells the stage when a HI/LO read must hold.
// Optional HILO_BYPASS_EN: the pending result is visible on rd_hi/rd_lo during the final cycle.
module md_unit
  import ex_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            rd_wait,
  output logic [XLEN-1:0] rd_hi,
  output logic [XLEN-1:0] rd_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CMAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  md_state_t         state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   op_a;      // raw dividend / multiplicand
  logic [XLEN-1:0]   op_b;      // raw multiplier, or divisor magnitude
  logic              sgn;
  logic              q_neg;
  logic              r_neg;
  logic              div_zero;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;       // dividend magnitude shifts out as quotient bits shift in

  logic              done;
  logic              is_mul_op;
  logic              is_signed_op;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  assign busy         = (state != ST_IDLE);
  assign done         = busy && (cnt == '0);
  assign is_mul_op    = (op == MD_MULT) || (op == MD_MULTU);
  assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign mag_a        = (is_signed_op && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b        = (is_signed_op && src_b[XLEN-1]) ? -src_b : src_b;

  // One restoring step: a negative trial keeps the shifted remainder and yields a 0 quotient bit.
  assign trial  = {rem, quo[XLEN-1]} - {1'b0, op_b};
  assign rem_nx = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ~trial[XLEN]};
  assign q_fix  = q_neg ? -quo_nx : quo_nx;
  assign r_fix  = r_neg ? -rem_nx : rem_nx;

  // Operands are sign- or zero-extended so one 2*XLEN multiply serves MULT and MULTU.
  assign ext_a = {{XLEN{sgn & op_a[XLEN-1]}}, op_a};
  assign ext_b = {{XLEN{sgn & op_b[XLEN-1]}}, op_b};
  assign prod  = ext_a * ext_b;

  // Final HI/LO values; divide by zero reports all-ones quotient and the untouched dividend.
  always_comb begin
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (state == ST_DIV) begin
      res_hi = div_zero ? op_a : r_fix;
      res_lo = div_zero ? '1 : q_fix;
    end
  end

`ifdef HILO_BYPASS_EN
  assign rd_wait = busy & ~done;
  assign rd_hi   = done ? res_hi : hi;
  assign rd_lo   = done ? res_lo : lo;
`else
  assign rd_wait = busy;
  assign rd_hi   = hi;
  assign rd_lo   = lo;
`endif

  // Issue captures operands and sign handling; afterwards the counter runs down once per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sgn      <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
      quo      <= '0;
    end else if (state == ST_IDLE) begin
      if (start && md_is_arith(op)) begin
        state    <= is_mul_op ? ST_MUL : ST_DIV;
        cnt      <= is_mul_op ? CW'(MUL_CYCLES - 1) : CW'(XLEN - 1);
        op_a     <= src_a;
        op_b     <= is_mul_op ? src_b : mag_b;
        sgn      <= is_signed_op;
        q_neg    <= is_signed_op & (src_a[XLEN-1] ^ src_b[XLEN-1]);
        r_neg    <= is_signed_op & src_a[XLEN-1];
        div_zero <= (src_b == '0);
        rem      <= '0;
        quo      <= mag_a;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (state == ST_DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
      end
      if (done) begin
        state <= ST_IDLE;
      end
    end
  end

  // HI/LO take the finished result, otherwise accepted MTHI/MTLO data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand/destination muxing, branch/jump targets, mult/div with HI/LO, EX/MEM register.
// Latency: one cycle into EX/MEM; mult/div results reach HI/LO MUL_CYCLES or XLEN cycles after issue.
// Backpressure: only HI/LO users raise stall_req while mult/div is busy; we=0 holds EX/MEM. Optional macro: HILO_BYPASS_EN.
module ex_stage_md
  import ex_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              in_valid,
  input  logic [3:0]        md_op,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero_in,
  input  logic [XLEN-1:0]   data_s,
  input  logic [XLEN-1:0]   data_t,
  input  logic [XLEN-1:0]   pc_next,
  input  logic [XLEN-1:0]   pc_jump,
  input  logic [XLEN-1:0]   immediate,
  input  logic [REG_AW-1:0] reg_t,
  input  logic [REG_AW-1:0] reg_d,
  input  logic              dst_reg,
  input  logic              is_link,
  input  logic              is_jump,
  input  logic              dst_jump,
  input  logic              is_branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_type,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  output logic              stall_req,
  output logic              md_busy,
  output logic [REG_AW-1:0] reg_probe,
  output logic [XLEN-1:0]   data_probe,
  output logic              write_probe,
  output logic              is_branch_out,
  output logic              is_jump_out,
  output logic              alu_zero,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_type_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [XLEN-1:0]   pc_branch,
  output logic [XLEN-1:0]   pc_jump_out,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   data_t_out,
  output logic [REG_AW-1:0] reg_addr,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

  logic              md_arith;
  logic              md_read;
  logic              hilo_use;
  logic              issue;
  logic              wr_hi;
  logic              wr_lo;
  logic              rd_wait;
  logic              bubble;
  logic [XLEN-1:0]   rd_hi;
  logic [XLEN-1:0]   rd_lo;
  logic [XLEN-1:0]   exout;
  logic [XLEN-1:0]   jump_tgt;
  logic [XLEN-1:0]   branch_tgt;
  logic [REG_AW-1:0] wreg;

  assign md_arith = md_is_arith(md_op);
  assign md_read  = (md_op == MD_MFHI) || (md_op == MD_MFLO);
  assign hilo_use = in_valid & md_is_hilo(md_op);

  // MFHI/MFLO may slip through on the final cycle when bypassing; every other HI/LO user waits for idle.
  assign stall_req = hilo_use & (md_read ? rd_wait : md_busy);
  assign issue     = we & in_valid & md_arith & ~md_busy;
  assign wr_hi     = we & in_valid & ~stall_req & (md_op == MD_MTHI);
  assign wr_lo     = we & in_valid & ~stall_req & (md_op == MD_MTLO);
  assign bubble    = stall_req | ~in_valid;

  assign wreg       = is_link ? LINK_REG : (dst_reg ? reg_d : reg_t);
  assign jump_tgt   = dst_jump ? data_s : pc_jump;
  assign branch_tgt = pc_next + (immediate << 2);

  // Result that this instruction hands to EX/MEM and to forwarding.
  always_comb begin
    exout = alu_result;
    if (is_link) begin
      exout = pc_next;
    end else if (md_op == MD_MFHI) begin
      exout = rd_hi;
    end else if (md_op == MD_MFLO) begin
      exout = rd_lo;
    end
  end

  assign reg_probe   = wreg;
  assign data_probe  = exout;
  assign write_probe = in_valid & reg_write & ~mem_to_reg & ~stall_req;

  md_unit #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .start   (issue),
    .op      (md_op),
    .src_a   (data_s),
    .src_b   (data_t),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (data_s),
    .busy    (md_busy),
    .rd_wait (rd_wait),
    .rd_hi   (rd_hi),
    .rd_lo   (rd_lo),
    .hi      (hi),
    .lo      (lo)
  );

  // EX/MEM register: loads the instruction or a zeroed bubble when enabled, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_branch_out  <= 1'b0;
      is_jump_out    <= 1'b0;
      alu_zero       <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      mem_type_out   <= 1'b0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      pc_branch      <= '0;
      pc_jump_out    <= '0;
      alu_out        <= '0;
      data_t_out     <= '0;
      reg_addr       <= '0;
    end else if (we) begin
      if (bubble) begin
        is_branch_out  <= 1'b0;
        is_jump_out    <= 1'b0;
        alu_zero       <= 1'b0;
        mem_read_out   <= 1'b0;
        mem_write_out  <= 1'b0;
        mem_type_out   <= 1'b0;
        mem_to_reg_out <= 1'b0;
        reg_write_out  <= 1'b0;
        pc_branch      <= '0;
        pc_jump_out    <= '0;
        alu_out        <= '0;
        data_t_out     <= '0;
        reg_addr       <= '0;
      end else begin
        is_branch_out  <= is_branch;
        is_jump_out    <= is_jump;
        alu_zero       <= alu_zero_in;
        mem_read_out   <= mem_read;
        mem_write_out  <= mem_write;
        mem_type_out   <= mem_type;
        mem_to_reg_out <= mem_to_reg;
        // mult/div write HI/LO, never the register file
        reg_write_out  <= reg_write & ~md_arith;
        pc_branch      <= branch_tgt;
        pc_jump_out    <= jump_tgt;
        alu_out        <= exout;
        data_t_out     <= data_t;
        reg_addr       <= wreg;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: directed scenarios followed by random traffic against a behavioural model.
// The model tracks mult/div as "cycles remaining" plus a result computed with plain arithmetic.
// Honours HILO_BYPASS_EN when the macro is defined for the build.
module tb_ex_stage_md;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 4;
  localparam int REG_AW     = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, in_valid;
  logic [3:0]  md_op;
  logic [31:0] alu_result, data_s, data_t, pc_next, pc_jump, immediate;
  logic        alu_zero_in;
  logic [4:0]  reg_t, reg_d;
  logic        dst_reg, is_link, is_jump, dst_jump, is_branch;
  logic        mem_read, mem_write, mem_type, mem_to_reg, reg_write;

  logic        stall_req, md_busy, write_probe;
  logic [4:0]  reg_probe, reg_addr;
  logic [31:0] data_probe;
  logic        is_branch_out, is_jump_out, alu_zero, mem_read_out, mem_write_out;
  logic        mem_type_out, mem_to_reg_out, reg_write_out;
  logic [31:0] pc_branch, pc_jump_out, alu_out, data_t_out, hi, lo;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic [7:0]  e_ctl;
  logic [31:0] e_pcb, e_pcj, e_alu, e_dt;
  logic [4:0]  e_ra;
  logic        last_stall, last_wp;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset), .we(we), .in_valid(in_valid), .md_op(md_op),
    .alu_result(alu_result), .alu_zero_in(alu_zero_in),
    .data_s(data_s), .data_t(data_t), .pc_next(pc_next), .pc_jump(pc_jump),
    .immediate(immediate), .reg_t(reg_t), .reg_d(reg_d),
    .dst_reg(dst_reg), .is_link(is_link), .is_jump(is_jump), .dst_jump(dst_jump),
    .is_branch(is_branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_type(mem_type), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .stall_req(stall_req), .md_busy(md_busy), .reg_probe(reg_probe),
    .data_probe(data_probe), .write_probe(write_probe),
    .is_branch_out(is_branch_out), .is_jump_out(is_jump_out), .alu_zero(alu_zero),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_type_out(mem_type_out), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .pc_branch(pc_branch), .pc_jump_out(pc_jump_out),
    .alu_out(alu_out), .data_t_out(data_t_out), .reg_addr(reg_addr),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    we = 1'b1; in_valid = 1'b0; md_op = 4'd0;
    alu_result = '0; alu_zero_in = 1'b0; data_s = '0; data_t = '0;
    pc_next = '0; pc_jump = '0; immediate = '0; reg_t = '0; reg_d = '0;
    dst_reg = 1'b0; is_link = 1'b0; is_jump = 1'b0; dst_jump = 1'b0; is_branch = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_type = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
  endtask

  task automatic model_reset();
    m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    e_ctl = '0; e_pcb = '0; e_pcj = '0; e_alu = '0; e_dt = '0; e_ra = '0;
  endtask

  task automatic reg_checks();
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("md_busy", 32'(md_busy), 32'(m_left > 0));
    chk("alu_out", alu_out, e_alu);
    chk("reg_addr", 32'(reg_addr), 32'(e_ra));
    chk("exmem_ctl", 32'({is_branch_out, is_jump_out, alu_zero, mem_read_out, mem_write_out,
                          mem_type_out, mem_to_reg_out, reg_write_out}), 32'(e_ctl));
    chk("pc_branch", pc_branch, e_pcb);
    chk("pc_jump_out", pc_jump_out, e_pcj);
    chk("data_t_out", data_t_out, e_dt);
  endtask

  // Checks combinational outputs for the current inputs, then advances the model past the next edge.
  task automatic model_cycle();
    logic        busy, fin, use_hl, arith, mfx, st, wp;
    logic [31:0] hv, lv, ex;
    logic [4:0]  wr;
    int          sa, sb;
    longint      p;
    logic [63:0] pu;
    busy   = (m_left > 0);
    fin    = (m_left == 1);
    use_hl = in_valid && (md_op >= 4'd1) && (md_op <= 4'd8);
    arith  = (md_op >= 4'd1) && (md_op <= 4'd4);
    mfx    = (md_op == 4'd5) || (md_op == 4'd6);
    st     = use_hl && busy;
    hv     = m_hi;
    lv     = m_lo;
`ifdef HILO_BYPASS_EN
    if (mfx && fin) st = 1'b0;
    if (fin) begin
      hv = m_phi;
      lv = m_plo;
    end
`endif
    ex = is_link ? pc_next : (md_op == 4'd5) ? hv : (md_op == 4'd6) ? lv : alu_result;
    wr = is_link ? 5'd31 : (dst_reg ? reg_d : reg_t);
    wp = in_valid && reg_write && !mem_to_reg && !st;
    chk("stall_req", 32'(stall_req), 32'(st));
    chk("md_busy_comb", 32'(md_busy), 32'(busy));
    chk("write_probe", 32'(write_probe), 32'(wp));
    chk("reg_probe", 32'(reg_probe), 32'(wr));
    chk("data_probe", data_probe, ex);
    last_stall = stall_req;
    last_wp    = write_probe;

    if (busy) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (we && in_valid && arith) begin
      case (md_op)
        4'd1: begin
          p = longint'($signed(data_s)) * longint'($signed(data_t));
          m_phi = p[63:32]; m_plo = p[31:0];
        end
        4'd2: begin
          pu = {32'd0, data_s} * {32'd0, data_t};
          m_phi = pu[63:32]; m_plo = pu[31:0];
        end
        4'd3: begin
          if (data_t == 32'd0) begin
            m_plo = 32'hFFFF_FFFF; m_phi = data_s;
          end else if (data_s == 32'h8000_0000 && data_t == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 32'd0;
          end else begin
            sa = data_s; sb = data_t;
            m_plo = sa / sb; m_phi = sa % sb;
          end
        end
        default: begin
          if (data_t == 32'd0) begin
            m_plo = 32'hFFFF_FFFF; m_phi = data_s;
          end else begin
            m_plo = data_s / data_t; m_phi = data_s % data_t;
          end
        end
      endcase
      m_left = (md_op <= 4'd2) ? MUL_CYCLES : XLEN;
    end
    if (we && in_valid && !st && md_op == 4'd7) m_hi = data_s;
    if (we && in_valid && !st && md_op == 4'd8) m_lo = data_s;
    if (we) begin
      if (st || !in_valid) begin
        e_ctl = '0; e_pcb = '0; e_pcj = '0; e_alu = '0; e_dt = '0; e_ra = '0;
      end else begin
        e_ctl = {is_branch, is_jump, alu_zero_in, mem_read, mem_write, mem_type, mem_to_reg,
                 reg_write && !arith};
        e_pcb = pc_next + (immediate << 2);
        e_pcj = dst_jump ? data_s : pc_jump;
        e_alu = ex;
        e_dt  = data_t;
        e_ra  = wr;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    reg_checks();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom();
    we = (r[3:0] != 4'd0);
    in_valid = (r[6:4] != 3'd0);
    md_op = 4'($urandom_range(0, 15));
    alu_result = $urandom(); data_s = pick_operand(); data_t = pick_operand();
    pc_next = $urandom(); pc_jump = $urandom(); immediate = $urandom();
    reg_t = r[11:7]; reg_d = r[16:12];
    alu_zero_in = r[17]; dst_reg = r[18]; is_link = r[19] & r[20]; is_jump = r[21];
    dst_jump = r[22]; is_branch = r[23]; mem_read = r[24]; mem_write = r[25];
    mem_type = r[26]; mem_to_reg = r[27]; reg_write = r[28];
  endtask

  initial begin
    int n;
    set_idle();
    model_reset();
    reset = 1'b1;
    #2;
    chk("reset_stall", 32'(stall_req), 32'd0);
    reg_checks();
    #10 reset = 1'b0;
    cycle();
    cycle();

    // MULT -3 * 7 with an ADD issued right behind it
    in_valid = 1'b1; md_op = 4'd1; data_s = 32'hFFFF_FFFD; data_t = 32'd7; reg_write = 1'b1;
    cycle();
    chk("mult_reg_write_masked", 32'(reg_write_out), 32'd0);
    md_op = 4'd0; alu_result = 32'h55; dst_reg = 1'b1; reg_d = 5'd5;
    cycle();
    chk("add_not_stalled", 32'(last_stall), 32'd0);
    chk("add_alu_out", alu_out, 32'h55);
    set_idle();
    repeat (3) cycle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100/7 followed immediately by MFLO, then MFHI
    in_valid = 1'b1; md_op = 4'd4; data_s = 32'd100; data_t = 32'd7;
    cycle();
    md_op = 4'd6; reg_write = 1'b1; dst_reg = 1'b1; reg_d = 5'd9; alu_result = 32'hDEAD;
    n = 0;
    do begin
      cycle();
      if (last_stall) n++;
    end while (last_stall && n < 40);
`ifdef HILO_BYPASS_EN
    chk("divu_stall_cycles", n, 32'd31);
`else
    chk("divu_stall_cycles", n, 32'd32);
`endif
    chk("mflo_result", alu_out, 32'd14);
    md_op = 4'd5;
    cycle();
    chk("mfhi_result", alu_out, 32'd2);

    // signed MIN / -1 and divide by zero
    set_idle();
    in_valid = 1'b1; md_op = 4'd3; data_s = 32'h8000_0000; data_t = 32'hFFFF_FFFF;
    cycle();
    set_idle();
    repeat (32) cycle();
    chk("div_min_lo", lo, 32'h8000_0000);
    chk("div_min_hi", hi, 32'd0);
    in_valid = 1'b1; md_op = 4'd3; data_s = 32'd5; data_t = 32'd0;
    cycle();
    set_idle();
    repeat (32) cycle();
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    // reset ten cycles into a divide, EX/MEM held non-zero beforehand
    in_valid = 1'b1; md_op = 4'd3; data_s = 32'd1000; data_t = 32'd3;
    is_branch = 1'b1; alu_result = 32'h1234; reg_t = 5'd7; pc_next = 32'h40;
    cycle();
    set_idle();
    we = 1'b0;
    repeat (10) cycle();
    chk("pre_reset_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_branch_out", 32'(is_branch_out), 32'd0);
    chk("rst_pc_branch", pc_branch, 32'd0);
    model_reset();
    #2 reset = 1'b0;
    we = 1'b1;
    cycle();

    // JAL and a backwards branch
    in_valid = 1'b1; is_link = 1'b1; is_jump = 1'b1; pc_next = 32'h400; reg_write = 1'b1;
    alu_result = 32'h777;
    cycle();
    chk("jal_write_probe", 32'(last_wp), 32'd1);
    chk("jal_reg_addr", 32'(reg_addr), 32'd31);
    chk("jal_alu_out", alu_out, 32'h400);
    is_link = 1'b0; is_jump = 1'b0; is_branch = 1'b1; immediate = 32'hFFFF_FFFF; reg_write = 1'b0;
    cycle();
    chk("branch_target", pc_branch, 32'h3FC);

    // we=0 for three cycles while a MULT runs
    set_idle();
    in_valid = 1'b1; md_op = 4'd2; data_s = 32'h12345; data_t = 32'h1000; alu_result = 32'h99;
    cycle();
    we = 1'b0; md_op = 4'd0; alu_result = 32'hBAD; is_branch = 1'b1;
    repeat (3) begin
      cycle();
      chk("hold_alu_out", alu_out, 32'h99);
    end
    set_idle();
    cycle();
    chk("held_mult_hi", hi, 32'd0);
    chk("held_mult_lo", lo, 32'h1234_5000);

    // random traffic
    repeat (600) begin
      rand_inputs();
      cycle();
    end
    set_idle();
    repeat (40) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
